// File: rtl/gl3_video_pkg.sv
// Shared types and sizing helpers for the gl3 video stream blocks.
package gl3_video_pkg;

  typedef enum logic [1:0] {PASS, FETCH, REPLAY} state_t;

  localparam int unsigned MAX_WIDTH_DEFAULT = 2048;

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/gl3_line_ram.sv
// Simple dual-port line buffer: one write port, one registered read port.
module gl3_line_ram
  import gl3_video_pkg::*;
#(
  parameter int unsigned D_WIDTH = 8,
  parameter int unsigned DEPTH   = MAX_WIDTH_DEFAULT,
  parameter int unsigned A_WIDTH = addr_width(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [A_WIDTH-1:0] waddr,
  input  logic [D_WIDTH-1:0] wdata,
  input  logic               re,
  input  logic [A_WIDTH-1:0] raddr,
  output logic [D_WIDTH-1:0] rdata
);

  logic [D_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/gl3_upscaler_2x2.sv
// 2x2 stream upscaler: each pixel emitted twice, each line emitted live
// then replayed once from a line buffer.
module gl3_upscaler_2x2
  import gl3_video_pkg::*;
#(
  parameter int unsigned D_WIDTH   = 8,
  parameter int unsigned MAX_WIDTH = MAX_WIDTH_DEFAULT,
  parameter int unsigned A_WIDTH   = addr_width(MAX_WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [D_WIDTH-1:0] up_data,
  input  logic               up_valid,
  input  logic               up_tlast,
  input  logic               up_tuser,
  output logic               up_ready,
  output logic [D_WIDTH-1:0] down_data,
  output logic               down_valid,
  output logic               down_tlast,
  output logic               down_tuser,
  input  logic               down_ready
);

  localparam int unsigned CW = A_WIDTH + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WIDTH);

  state_t             state;
  logic               phase;
  logic [CW-1:0]      wr_addr, line_len, rd_idx;
  logic [D_WIDTH-1:0] pix, rdata;
  logic               down_hs, up_hs, last_pix, we, re;
  logic [A_WIDTH-1:0] raddr;

  assign last_pix = (rd_idx == line_len - CW'(1));
  assign down_hs  = down_valid & down_ready;
  assign up_hs    = up_valid & up_ready;

  // Control outputs are forced low while reset is held, even though PASS is combinational.
  always_comb begin
    down_data  = up_data;
    down_valid = 1'b0;
    down_tlast = 1'b0;
    down_tuser = 1'b0;
    up_ready   = 1'b0;
    if (rst) begin
      case (state)
        PASS: begin
          down_valid = up_valid;
          up_ready   = down_ready & phase;
          down_tuser = up_tuser & ~phase;
          down_tlast = up_tlast & phase;
        end
        REPLAY: begin
          down_data  = pix;
          down_valid = 1'b1;
          down_tlast = phase & last_pix;
        end
        default: ;
      endcase
    end
  end

  // Address 0 is read on the PASS exit edge so FETCH costs only one bubble.
  always_comb begin
    we    = (state == PASS) & down_hs & ~phase & (wr_addr < MAX_CNT);
    re    = 1'b0;
    raddr = '0;
    case (state)
      PASS:    re = up_hs & up_tlast;
      FETCH: begin
        re    = 1'b1;
        raddr = A_WIDTH'(1);
      end
      REPLAY: begin
        re    = down_hs & phase;
        raddr = A_WIDTH'(rd_idx + CW'(2));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= PASS;
      phase    <= 1'b0;
      wr_addr  <= '0;
      line_len <= '0;
      rd_idx   <= '0;
      pix      <= '0;
    end else begin
      if (down_hs) phase <= ~phase;
      case (state)
        PASS: begin
          if (down_hs && !phase && wr_addr < MAX_CNT) wr_addr <= wr_addr + CW'(1);
          if (up_hs && up_tlast) begin
            line_len <= wr_addr;
            wr_addr  <= '0;
            state    <= FETCH;
          end
        end
        FETCH: begin
          pix    <= rdata;
          rd_idx <= '0;
          state  <= REPLAY;
        end
        REPLAY: begin
          if (down_hs && phase) begin
            pix    <= rdata;
            rd_idx <= rd_idx + CW'(1);
            if (last_pix) state <= PASS;
          end
        end
        default: state <= PASS;
      endcase
    end
  end

  gl3_line_ram #(
    .D_WIDTH(D_WIDTH),
    .DEPTH  (MAX_WIDTH),
    .A_WIDTH(A_WIDTH)
  ) u_line_ram (
    .clk  (clk),
    .we   (we),
    .waddr(wr_addr[A_WIDTH-1:0]),
    .wdata(up_data),
    .re   (re),
    .raddr(raddr),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_gl3_upscaler_2x2.sv
// Scoreboard bench for gl3_upscaler_2x2 with a 4-pixel line buffer.
module tb_gl3_upscaler_2x2;

  localparam int unsigned MAXW = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] up_data = '0;
  logic       up_valid = 1'b0, up_tlast = 1'b0, up_tuser = 1'b0;
  logic       up_ready;
  logic [7:0] down_data;
  logic       down_valid, down_tlast, down_tuser;
  logic       down_ready = 1'b1;

  gl3_upscaler_2x2 #(
    .D_WIDTH  (8),
    .MAX_WIDTH(MAXW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .up_data   (up_data),
    .up_valid  (up_valid),
    .up_tlast  (up_tlast),
    .up_tuser  (up_tuser),
    .up_ready  (up_ready),
    .down_data (down_data),
    .down_valid(down_valid),
    .down_tlast(down_tlast),
    .down_tuser(down_tuser),
    .down_ready(down_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       tlast;
    logic       tuser;
  } beat_t;

  typedef struct {
    beat_t b;
    int    gap;
  } exp_t;

  exp_t  sb[$];
  int    vectors = 0;
  int    errors  = 0;
  bit    chk_gap = 1'b0;
  bit    rand_ready = 1'b0;
  int    idle = 0;
  bit    stalled = 1'b0;
  beat_t held, got;
  exp_t  e;

  function automatic void push(input logic [7:0] d, input logic l, input logic u, input int g);
    exp_t x;
    x.b   = '{data: d, tlast: l, tuser: u};
    x.gap = g;
    sb.push_back(x);
  endfunction

  // Monitor: samples on the falling edge, handshake completes on the next rising edge.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      stalled = 1'b0;
      idle    = 0;
    end else begin
      got = {down_data, down_tlast, down_tuser};
      if (stalled) begin
        vectors++;
        if (!down_valid || got != held) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b %h/%0b/%0b want v=1 %h/%0b/%0b",
                   down_valid, got.data, got.tlast, got.tuser, held.data, held.tlast, held.tuser);
        end
      end
      stalled = down_valid && !down_ready;
      held    = got;
      if (down_valid && down_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL extra_beat: got %h/%0b/%0b want no beat", got.data, got.tlast, got.tuser);
        end else begin
          e = sb.pop_front();
          if (got != e.b) begin
            errors++;
            $display("FAIL beat: got %h/%0b/%0b want %h/%0b/%0b",
                     got.data, got.tlast, got.tuser, e.b.data, e.b.tlast, e.b.tuser);
          end
          if (chk_gap && e.gap >= 0) begin
            vectors++;
            if (idle != e.gap) begin
              errors++;
              $display("FAIL gap: got %0d idle cycles want %0d before %h", idle, e.gap, e.b.data);
            end
          end
        end
        idle = 0;
      end else if (!down_valid) begin
        idle++;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    down_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic send_px(input logic [7:0] d, input logic last, input logic user);
    bit ok;
    ok       = 1'b0;
    up_data  = d;
    up_tlast = last;
    up_tuser = user;
    up_valid = 1'b1;
    for (int n = 0; n < 1000 && !ok; n++) begin
      @(negedge clk);
      ok = up_ready;
    end
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL up_timeout: got no up_ready want accept of %h", d);
    end
    @(posedge clk);
    #1;
    up_valid = 1'b0;
    up_tlast = 1'b0;
    up_tuser = 1'b0;
  endtask

  // px holds pixel i in byte i; expected rows are pushed before the line is driven.
  task automatic send_line(input logic [63:0] px, input int n, input bit user,
                           input int idle_cycles, input int first_gap);
    int stored;
    stored = (n < int'(MAXW)) ? n : int'(MAXW);
    for (int i = 0; i < n; i++) begin
      push(px[i*8 +: 8], 1'b0, user && i == 0, (i == 0) ? first_gap : idle_cycles);
      push(px[i*8 +: 8], i == n - 1, 1'b0, 0);
    end
    for (int i = 0; i < stored; i++) begin
      push(px[i*8 +: 8], 1'b0, 1'b0, (i == 0) ? 1 : 0);
      push(px[i*8 +: 8], i == stored - 1, 1'b0, 0);
    end
    for (int i = 0; i < n; i++) begin
      send_px(px[i*8 +: 8], i == n - 1, user && i == 0);
      if (i != n - 1) repeat (idle_cycles) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 2000 && sb.size() != 0; n++) @(posedge clk);
    vectors++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d beats outstanding want 0", sb.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got no completion want finish before 200us");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $fatal(1);
  end

  initial begin
    // Reset state with inputs trying to push data through.
    up_valid = 1'b1;
    up_tlast = 1'b1;
    up_tuser = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (up_ready !== 1'b0 || down_valid !== 1'b0 || down_tlast !== 1'b0 || down_tuser !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b v=%b l=%b u=%b want all 0",
               up_ready, down_valid, down_tlast, down_tuser);
    end
    up_valid = 1'b0;
    up_tlast = 1'b0;
    up_tuser = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // 4x2 frame, full throughput.
    chk_gap = 1'b1;
    send_line(64'h13121110, 4, 1'b1, 0, -1);
    send_line(64'h23222120, 4, 1'b0, 0, 0);
    drain();

    // Same frame under random backpressure.
    chk_gap    = 1'b0;
    rand_ready = 1'b1;
    send_line(64'h13121110, 4, 1'b1, 0, -1);
    send_line(64'h23222120, 4, 1'b0, 0, 0);
    drain();
    rand_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Input bubbles between pixels in PASS.
    chk_gap = 1'b1;
    send_line(64'h13121110, 4, 1'b1, 2, -1);
    drain();

    // Line longer than the buffer: replay truncates to MAXW pixels.
    send_line(64'h050403020100, 6, 1'b1, 0, -1);
    drain();

    // Reset three beats into the replay.
    send_line(64'hB3B2B1B0, 4, 1'b1, 0, -1);
    repeat (5) void'(sb.pop_back());
    for (int n = 0; n < 500 && sb.size() != 0; n++) @(posedge clk);
    #1;
    rst      = 1'b0;
    up_data  = 8'hEE;
    up_valid = 1'b1;
    #1;
    vectors++;
    if (down_valid !== 1'b0 || up_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_replay_reset: got v=%b rdy=%b want v=0 rdy=0", down_valid, up_ready);
    end
    up_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    send_line(64'hA3A2A1A0, 4, 1'b1, 0, -1);
    drain();

    // Single-pixel line.
    send_line(64'h55, 1, 1'b1, 0, -1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
